// File: rtl/kernel_run_ctrl.sv
// Session controller: launches an HLS kernel RUN_NUM times with idle gaps, cycling datasets.
// Define RUN_CYCLE_CNT_EN to enable the per-run latency counter on cycle_cnt.

module kernel_run_ctrl #(
    parameter int  RUN_NUM        = 16,
    parameter int  GAP_CYCLES     = 4,
    parameter int  DATASET_NUM    = 8,
    parameter int  RAM_UPDATE_INV = 1,
    parameter int  CNT_WIDTH      = 32,
    localparam int IDX_W          = $clog2(DATASET_NUM)
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 req_start,
    input  logic                 abort,
    output logic                 kernel_ap_start,
    input  logic                 kernel_ap_ready,
    input  logic                 kernel_ap_done,
    output logic                 busy,
    output logic                 session_done,
    output logic [IDX_W-1:0]     dataset_idx,
    output logic                 ram_update,
    output logic [15:0]          run_cnt,
    output logic [CNT_WIDTH-1:0] cycle_cnt
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam int RAM_W = $clog2(RAM_UPDATE_INV + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [RAM_W-1:0] RAM_LAST = RAM_W'(RAM_UPDATE_INV - 1);
    localparam logic [16:0]      RUN_LAST = 17'(RUN_NUM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_GAP,
        S_FINISH
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [2:0]         sync_q;
    logic [1:0]         sync_fill;
    logic               armed;
    logic               trigger;
    logic               abort_flag;
    logic               abort_seen;
    logic               completion;
    logic               last_run;
    logic [GAP_W-1:0]   gap_cnt;
    logic [RAM_W-1:0]   ram_div;

    // armed only after the synchronized request has been seen low, so a level
    // held high across reset release cannot masquerade as a rising edge
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            sync_q    <= '0;
            sync_fill <= '0;
            armed     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], req_start};
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && !sync_q[1]) begin
                armed <= 1'b1;
            end
        end
    end

    assign trigger    = armed & sync_q[1] & ~sync_q[2];
    assign abort_seen = abort_flag | abort;
    assign last_run   = ({1'b0, run_cnt} + 17'd1) == RUN_LAST;

    always_comb begin
        next_state = state;
        completion = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                if (kernel_ap_ready) begin
                    if (kernel_ap_done) begin
                        completion = 1'b1;
                    end else begin
                        next_state = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (kernel_ap_done) begin
                    completion = 1'b1;
                end
            end
            S_GAP: begin
                if (abort_seen) begin
                    next_state = S_FINISH;
                end else if (gap_cnt <= GAP_W'(1)) begin
                    next_state = S_START;
                end
            end
            S_FINISH: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (completion) begin
            if (last_run || abort_seen) begin
                next_state = S_FINISH;
            end else if (GAP_CYCLES == 0) begin
                next_state = S_START;
            end else begin
                next_state = S_GAP;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= S_IDLE;
            abort_flag <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_IDLE) begin
                abort_flag <= 1'b0;
            end else if (abort) begin
                abort_flag <= 1'b1;
            end
        end
    end

    // run_cnt and dataset_idx hold after a session so software can read them
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            run_cnt     <= '0;
            dataset_idx <= '0;
            ram_div     <= '0;
            ram_update  <= 1'b0;
        end else begin
            ram_update <= 1'b0;
            if (state == S_IDLE && trigger) begin
                run_cnt     <= '0;
                dataset_idx <= '0;
                ram_div     <= '0;
            end
            if (completion) begin
                run_cnt     <= run_cnt + 16'd1;
                dataset_idx <= dataset_idx + IDX_W'(1);
                if (ram_div == RAM_LAST) begin
                    ram_div    <= '0;
                    ram_update <= 1'b1;
                end else begin
                    ram_div <= ram_div + RAM_W'(1);
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            gap_cnt <= '0;
        end else if (next_state == S_GAP && state != S_GAP) begin
            gap_cnt <= GAP_LOAD;
        end else if (state == S_GAP) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    assign kernel_ap_start = (state == S_START);
    assign busy            = (state != S_IDLE);
    assign session_done    = (state == S_FINISH);

`ifdef RUN_CYCLE_CNT_EN
    logic [CNT_WIDTH-1:0] run_cyc;
    logic [CNT_WIDTH-1:0] run_cyc_inc;
    logic [CNT_WIDTH-1:0] cycle_cnt_q;
    logic                 start_entry;

    assign run_cyc_inc = (&run_cyc) ? run_cyc : run_cyc + CNT_WIDTH'(1);
    assign start_entry = (next_state == S_START) && ((state != S_START) || completion);

    // the captured value includes the START cycles and the done cycle itself
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            run_cyc     <= '0;
            cycle_cnt_q <= '0;
        end else begin
            if (start_entry) begin
                run_cyc <= '0;
            end else if (state == S_START || state == S_RUN) begin
                run_cyc <= run_cyc_inc;
            end
            if (completion) begin
                cycle_cnt_q <= run_cyc_inc;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_kernel_run_ctrl.sv
// Self-checking bench for kernel_run_ctrl: table-driven and random sessions against a
// session-level reference model, plus reset, abort and zero-gap corner sequences.

module tb_kernel_run_ctrl;

    localparam int RUN_NUM_A = 10;
    localparam int GAP_A     = 4;
    localparam int DS_A      = 8;
    localparam int INV_A     = 3;
    localparam int RUN_NUM_B = 5;
    localparam int DS_B      = 4;

    typedef struct {
        int ready_dly;
        int done_dly;
        int abort_run;
        int toggle;
        int spur;
        int exp_runs;
        int exp_idx;
        int exp_ram;
    } vec_t;

    logic        ap_clk;
    logic        ap_rst;
    logic        req_start;
    logic        abort;
    logic        spur_done;
    logic        kernel_ap_start;
    logic        kernel_ap_ready;
    logic        kernel_ap_done;
    logic        busy;
    logic        session_done;
    logic [2:0]  dataset_idx;
    logic        ram_update;
    logic [15:0] run_cnt;
    logic [31:0] cycle_cnt;

    logic        req_start_b;
    logic        abort_b;
    logic        start_b;
    logic        busy_b;
    logic        session_done_b;
    logic [1:0]  ds_b;
    logic        ram_b;
    logic [15:0] run_cnt_b;
    logic [31:0] cyc_b;

    int   n_checks = 0;
    int   n_fail   = 0;

    int   ready_dly;
    int   done_dly;
    bit   k_active   = 1'b0;
    int   k_cyc      = 0;
    logic k_ready    = 1'b0;
    logic k_done     = 1'b0;
    logic prev_start = 1'b0;
    bit   gap_armed  = 1'b0;
    int   gap_cnt_m  = 0;
    int   starts     = 0;
    int   sess_n     = 0;
    int   ds_q[$];
    int   gap_q[$];
    int   ram_q[$];
    logic prev_b     = 1'b0;
    int   b_high     = 0;
    int   b_rises    = 0;
    int   b_ram      = 0;
    int   b_done     = 0;

    vec_t tbl[4];

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    assign kernel_ap_ready = k_ready;
    assign kernel_ap_done  = k_done | spur_done;

    kernel_run_ctrl #(
        .RUN_NUM(RUN_NUM_A), .GAP_CYCLES(GAP_A), .DATASET_NUM(DS_A),
        .RAM_UPDATE_INV(INV_A), .CNT_WIDTH(32)
    ) u_dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .req_start(req_start), .abort(abort),
        .kernel_ap_start(kernel_ap_start), .kernel_ap_ready(kernel_ap_ready),
        .kernel_ap_done(kernel_ap_done), .busy(busy), .session_done(session_done),
        .dataset_idx(dataset_idx), .ram_update(ram_update), .run_cnt(run_cnt),
        .cycle_cnt(cycle_cnt)
    );

    // zero-gap instance whose kernel accepts and finishes in the START cycle
    kernel_run_ctrl #(
        .RUN_NUM(RUN_NUM_B), .GAP_CYCLES(0), .DATASET_NUM(DS_B),
        .RAM_UPDATE_INV(1), .CNT_WIDTH(32)
    ) u_dut_b (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .req_start(req_start_b), .abort(abort_b),
        .kernel_ap_start(start_b), .kernel_ap_ready(start_b),
        .kernel_ap_done(start_b), .busy(busy_b), .session_done(session_done_b),
        .dataset_idx(ds_b), .ram_update(ram_b), .run_cnt(run_cnt_b),
        .cycle_cnt(cyc_b)
    );

    // kernel model and transaction monitor, both evaluated mid-cycle
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            k_active = 1'b0;
        end else if (k_active) begin
            if (k_cyc >= done_dly) k_active = 1'b0;
            else k_cyc++;
        end else if (kernel_ap_start) begin
            k_active = 1'b1;
            k_cyc    = 0;
        end
        k_ready = k_active && (k_cyc == ready_dly);
        k_done  = k_active && (k_cyc == done_dly);

        if (kernel_ap_start && !prev_start) begin
            starts++;
            ds_q.push_back(int'(dataset_idx));
            if (gap_armed) begin
                gap_q.push_back(gap_cnt_m);
                gap_armed = 1'b0;
            end
        end else if (gap_armed && !kernel_ap_start) begin
            gap_cnt_m++;
        end
        if (k_done) begin
            gap_armed = 1'b1;
            gap_cnt_m = 0;
        end
        if (!busy) gap_armed = 1'b0;
        if (session_done) sess_n++;
        if (ram_update) ram_q.push_back(int'(run_cnt));
        prev_start = kernel_ap_start;

        if (start_b) b_high++;
        if (start_b && !prev_b) b_rises++;
        if (ram_b) b_ram++;
        if (session_done_b) b_done++;
        prev_b = start_b;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // reference model: a session ends after RUN_NUM runs, or after the run in
    // flight (or the gap following it) when abort was raised
    function automatic vec_t modelSession(input int r, input int d, input int ab, input int sp);
        vec_t v;
        v.ready_dly = r;
        v.done_dly  = d;
        v.abort_run = ab;
        v.toggle    = 0;
        v.spur      = sp;
        v.exp_runs  = (ab == 0) ? RUN_NUM_A : ab;
        v.exp_idx   = v.exp_runs % DS_A;
        v.exp_ram   = v.exp_runs / INV_A;
        return v;
    endfunction

    function automatic int expCycleCnt(input int d);
`ifdef RUN_CYCLE_CNT_EN
        return d + 1;
`else
        return (d < 0) ? 1 : 0;
`endif
    endfunction

    task automatic applyStimulus(input vec_t v);
        int s0, g0, d0, r0, q0, cyc, budget, abort_at, tog_at;
        bit finished, busy_seen;
        ready_dly = v.ready_dly;
        done_dly  = v.done_dly;
        @(posedge ap_clk); #2;
        s0 = starts; g0 = gap_q.size(); d0 = sess_n; r0 = ram_q.size(); q0 = ds_q.size();
        req_start = 1'b1;
        cyc = 0; abort_at = -1; tog_at = -1; finished = 1'b0;
        budget = 40 + RUN_NUM_A * (v.done_dly + GAP_A + 4);
        while (!finished && cyc < budget) begin
            @(posedge ap_clk); #2;
            cyc++;
            abort     = 1'b0;
            spur_done = 1'b0;
            if (v.abort_run > 0 && abort_at < 0 && starts - s0 >= v.abort_run) abort_at = cyc + 2;
            if (cyc == abort_at) abort = 1'b1;
            if (v.toggle != 0) begin
                if (tog_at < 0 && starts - s0 >= 1) tog_at = cyc;
                req_start = (tog_at < 0 || cyc >= tog_at + 5) ? 1'b1 : 1'b0;
            end
            if (v.spur != 0 && starts - s0 == 1 && gap_q.size() == g0 && gap_armed && gap_cnt_m == 1)
                spur_done = 1'b1;
            finished = (sess_n > d0);
        end
        abort     = 1'b0;
        spur_done = 1'b0;
        checkOutput("session_end", finished, 1);
        @(negedge ap_clk);
        checkOutput("busy_after", busy, 0);
        checkOutput("run_cnt", run_cnt, v.exp_runs);
        checkOutput("dataset_idx", dataset_idx, v.exp_idx);
        checkOutput("start_pulses", starts - s0, v.exp_runs);
        checkOutput("ram_pulses", ram_q.size() - r0, v.exp_ram);
        for (int i = r0; i < ram_q.size(); i++)
            checkOutput($sformatf("ram_at_run[%0d]", i - r0), ram_q[i], (i - r0 + 1) * INV_A);
        checkOutput("gap_count", gap_q.size() - g0, v.exp_runs - 1);
        for (int i = g0; i < gap_q.size(); i++)
            checkOutput($sformatf("gap_len[%0d]", i - g0), gap_q[i], GAP_A);
        for (int i = q0; i < ds_q.size(); i++)
            checkOutput($sformatf("dataset_seq[%0d]", i - q0), ds_q[i], (i - q0) % DS_A);
        checkOutput("cycle_cnt", cycle_cnt, expCycleCnt(v.done_dly));
        busy_seen = 1'b0;
        repeat (8) begin
            @(negedge ap_clk);
            if (busy) busy_seen = 1'b1;
        end
        checkOutput("no_retrigger", busy_seen, 0);
        checkOutput("session_done_once", sess_n - d0, 1);
        @(posedge ap_clk); #2;
        req_start = 1'b0;
        repeat (5) @(posedge ap_clk);
    endtask

    initial begin
        int s0, d0, cyc;
        bit busy_seen;
        vec_t rv;
        ap_rst = 1'b1; req_start = 1'b0; abort = 1'b0; spur_done = 1'b0;
        req_start_b = 1'b0; abort_b = 1'b0;
        ready_dly = 1; done_dly = 1;

        tbl[0] = '{1, 101, 0, 1, 0, 10, 2, 3};
        tbl[1] = '{0,   0, 0, 0, 0, 10, 2, 3};
        tbl[2] = '{2,   5, 2, 0, 1,  2, 2, 0};
        tbl[3] = '{1,  50, 4, 1, 0,  4, 4, 1};

        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_start", kernel_ap_start, 0);
        checkOutput("rst_session_done", session_done, 0);
        checkOutput("rst_ram_update", ram_update, 0);
        checkOutput("rst_run_cnt", run_cnt, 0);
        checkOutput("rst_dataset_idx", dataset_idx, 0);
        checkOutput("rst_cycle_cnt", cycle_cnt, 0);
        checkOutput("rst_busy_b", busy_b, 0);
        @(posedge ap_clk); #2;
        ap_rst = 1'b0;
        repeat (4) @(posedge ap_clk);

        for (int i = 0; i < 4; i++) begin
            $display("[TB] table vector %0d", i);
            applyStimulus(tbl[i]);
        end

        for (int i = 0; i < 6; i++) begin
            int r, d, ab, sp;
            r  = int'($urandom_range(0, 3));
            d  = r + int'($urandom_range(0, 20));
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, RUN_NUM_A)) : 0;
            sp = int'($urandom_range(0, 1));
            rv = modelSession(r, d, ab, sp);
            $display("[TB] random session %0d ready=%0d done=%0d abort_run=%0d", i, r, d, ab);
            applyStimulus(rv);
        end

        // reset in the middle of run 2 with the request level held high
        $display("[TB] reset mid-run sequence");
        ready_dly = 1; done_dly = 60;
        @(posedge ap_clk); #2;
        s0 = starts; req_start = 1'b1; cyc = 0;
        while (!(starts - s0 >= 2 && k_active && k_cyc >= 10) && cyc < 400) begin
            @(posedge ap_clk); #2;
            cyc++;
        end
        checkOutput("reach_run2", (starts - s0 >= 2), 1);
        checkOutput("run_cnt_before_reset", run_cnt, 1);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_start", kernel_ap_start, 0);
        checkOutput("mid_rst_run_cnt", run_cnt, 0);
        checkOutput("mid_rst_dataset_idx", dataset_idx, 0);
        checkOutput("mid_rst_session_done", session_done, 0);
        checkOutput("mid_rst_ram_update", ram_update, 0);
        checkOutput("mid_rst_cycle_cnt", cycle_cnt, 0);
        @(posedge ap_clk); #2;
        ap_rst = 1'b0;
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge ap_clk);
            if (busy) busy_seen = 1'b1;
        end
        checkOutput("held_high_no_session", busy_seen, 0);
        @(posedge ap_clk); #2;
        req_start = 1'b0;
        repeat (5) @(posedge ap_clk);
        #2;
        req_start = 1'b1;
        cyc = 0;
        while (!busy && cyc < 10) begin
            @(posedge ap_clk); #2;
            cyc++;
        end
        checkOutput("restart_after_edge", busy, 1);
        d0 = sess_n;
        abort = 1'b1;
        @(posedge ap_clk); #2;
        abort = 1'b0;
        cyc = 0;
        while (sess_n == d0 && cyc < 200) begin
            @(posedge ap_clk); #2;
            cyc++;
        end
        checkOutput("abort_session_end", sess_n - d0, 1);
        checkOutput("abort_run_cnt", run_cnt, 1);
        req_start = 1'b0;
        repeat (5) @(posedge ap_clk);

        // zero gap, kernel ready and done in the START cycle
        $display("[TB] zero-gap back-to-back sequence");
        #2;
        req_start_b = 1'b1;
        cyc = 0;
        while (b_done == 0 && cyc < 60) begin
            @(posedge ap_clk); #2;
            cyc++;
        end
        @(negedge ap_clk);
        checkOutput("b_session_done", b_done, 1);
        checkOutput("b_start_rises", b_rises, 1);
        checkOutput("b_start_cycles", b_high, RUN_NUM_B);
        checkOutput("b_run_cnt", run_cnt_b, RUN_NUM_B);
        checkOutput("b_dataset_idx", ds_b, RUN_NUM_B % DS_B);
        checkOutput("b_ram_pulses", b_ram, RUN_NUM_B);
        checkOutput("b_busy_after", busy_b, 0);
        checkOutput("b_cycle_cnt", cyc_b, expCycleCnt(0));
        req_start_b = 1'b0;
        repeat (3) @(posedge ap_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
